ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 clk  input  1  system clock; one machine sub-cycle (A1..X3) per rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cycle  output  3  current sub-cycle: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3; drives the program ROM.
REQ-004 addr  output  12  fetch address to the ROM, equal to the internal PC during all eight sub-cycles.
REQ-005 nibble  input  4  ROM data; valid only in M1 and M2, high-impedance otherwise.
REQ-006 hold  input  1  stall request; honoured only at X3.
REQ-007 pc_load  input  1  jump request from the executing core; sampled at X3.
REQ-008 pc_load_addr  input  12  jump target; sampled together with pc_load.
REQ-009 opr  output  4  upper nibble of the first instruction byte.
REQ-010 opa  output  4  lower nibble of the first instruction byte.
REQ-011 operand  output  8  second byte of a two-byte instruction; 0 for one-byte instructions.
REQ-012 two_byte  output  1  the presented instruction is two bytes long.
REQ-013 instr_valid  output  1  single-clock pulse; opr, opa, operand and two_byte are valid and stable until the next pulse.

Function
REQ-014 The cycle SHALL advance 0..7 and wrap 7->0 on every clock edge, except as stated in REQ-015.
REQ-015 If hold=1 in X3, cycle SHALL remain 7 and PC, state and outputs SHALL be unchanged; on release, the fetch resumes with A1.
REQ-016 In M1, nibble SHALL be captured into opr in byte state FIRST, or into operand[7:4] in state SECOND.
REQ-017 In M2, nibble SHALL be captured into opa in state FIRST, or into operand[3:0] in state SECOND.
REQ-018 nibble SHALL be ignored in all sub-cycles other than M1 and M2.
REQ-019 Two-byte opcodes:
  - opr=0x1 (JCN), 0x4 (JUN), 0x5 (JMS), 0x7 (ISZ);
  - opr=0x2 with opa[0]=0 (FIM);
  - opr=0x2 with opa[0]=1 (SRC) is one byte, as are all other opcodes.
REQ-020 At X3 in FIRST with a two-byte opcode, the block SHALL increment the PC, enter SECOND, and not pulse instr_valid; pc_load is ignored.
REQ-021 At X3 in FIRST with a one-byte opcode, or in SECOND, the block SHALL:
  - set PC to pc_load_addr if pc_load=1, otherwise to PC+1;
  - enter FIRST;
  - assert instr_valid in the following clock (A1 of the next fetch).
REQ-022 PC increment SHALL be modulo 4096 (0xFFF -> 0x000), including between the two bytes of an instruction.
REQ-023 operand SHALL be cleared to 0 and two_byte set to 0 when a one-byte instruction is presented.
REQ-024 Latency SHALL be:
  - one-byte instruction: 8 clocks from A1 to instr_valid;
  - two-byte instruction: 16 clocks from A1 to instr_valid.

Reset
REQ-025 While rst_n=0, the block SHALL hold:
  - cycle=0, PC/addr=0x000;
  - opr, opa, operand = 0;
  - two_byte=0, instr_valid=0;
  - state FIRST.
REQ-026 Reset asserted mid-fetch, including in SECOND, SHALL abandon the fetch with no instr_valid pulse; the first edge after release begins A1→A2 at 0x000.

Structure
REQ-027 The cycle encodings (A1..X3), opcode constants (JCN, FIM/SRC, JUN, JMS, ISZ) and the byte-state encoding SHALL live in the shared package tb4004_pkg.
REQ-028 The phase counter with hold SHALL be a sub-module cycle_timer (ports clk, rst_n, hold, cycle); the PC, capture and byte-state logic SHALL live in ifetch.

Verification
REQ-029 ROM 0x000=0x00, 0x001=0x85, 0x002=0x97 → three pulses 8 clocks apart: (opr,opa) = (0,0), (8,5), (9,7); addr = 0x001, 0x002, 0x003 after each.
REQ-030 ROM 0x000=0x40, 0x001=0x10 (JUN) → no pulse at clock 8; at clock 16 pulse with opr=4, opa=0, operand=0x10, two_byte=1.
REQ-031 FIM/SRC: 0x22 fetches two bytes; 0x23 presents one-byte with operand=0.
REQ-032 PC=0xFFF, ROM 0xFFF=0x00 → after X3, addr=0x000; pc_load=1 with pc_load_addr=0x123 at X3 → next addr=0x123.
REQ-033 hold=1 for 5 clocks at X3 → cycle stays 7 for 5 clocks, addr unchanged; resumes at A1.
REQ-034 rst_n pulsed low at M1 of the second byte of a JUN → no instr_valid, and fetch restarts at 0x000 in FIRST.

Source files
------------

// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004-style instruction fetch slice.
//   cycle_t       : machine sub-cycle encoding A1..X3 (0..7), as seen by the ROM
//   byte_state_t  : which instruction byte the current fetch is collecting
//   OPR_*         : upper-nibble opcodes that matter to the fetch unit
//   is_two_byte() : decides from the first byte whether a second byte follows
package tb4004_pkg;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } cycle_t;

  typedef enum logic {
    BYTE_FIRST  = 1'b0,
    BYTE_SECOND = 1'b1
  } byte_state_t;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;  // opa[0] selects FIM (0) or SRC (1)
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  function automatic logic is_two_byte(input logic [3:0] opr, input logic [3:0] opa);
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: return 1'b1;
      OPR_FIM_SRC:                        return ~opa[0];
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Machine sub-cycle counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   hold       : stall request, only honoured while the counter sits at X3
//   cycle      : current sub-cycle 0..7 (A1..X3), wraps X3 -> A1
module cycle_timer
  import tb4004_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  output logic [2:0] cycle
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle <= A1;
    end else if (!(cycle == X3 && hold)) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      cycle <= cycle + 3'd1;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: walks the eight sub-cycles, presents the PC to the
// ROM, captures one or two instruction bytes nibble by nibble and presents
// the decoded fields with a one-clock instr_valid pulse at A1.
//   clk, rst_n       : clock, asynchronous active-low reset
//   cycle, addr      : sub-cycle and fetch address driven to the ROM
//   nibble           : ROM data, meaningful only in M1/M2
//   hold             : stall at X3
//   pc_load(_addr)   : jump request/target, sampled at the closing X3
//   opr, opa         : first instruction byte, upper/lower nibble
//   operand          : second byte (0 for one-byte instructions)
//   two_byte         : presented instruction had a second byte
//   instr_valid      : one-clock pulse when the above are updated
module ifetch
  import tb4004_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [2:0]  cycle,
  output logic [11:0] addr,
  input  logic [3:0]  nibble,
  input  logic        hold,
  input  logic        pc_load,
  input  logic [11:0] pc_load_addr,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [7:0]  operand,
  output logic        two_byte,
  output logic        instr_valid
);

  cycle_t      phase;
  byte_state_t state, state_next;
  logic [11:0] pc, pc_next;
  logic        fetch_done;

  cycle_timer u_cycle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .cycle (cycle)
  );

  assign phase = cycle_t'(cycle);
  assign addr  = pc;

  // Decision taken at the closing X3 of each byte. A held X3 is not a
  // closing edge, so nothing moves while hold is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    pc_next    = pc;
    fetch_done = 1'b0;
    if (phase == X3 && !hold) begin
      if (state == BYTE_FIRST && is_two_byte(opr, opa)) begin
        // First byte of a two-byte instruction: jumps wait for the full word.
        pc_next    = pc + 12'd1;
        state_next = BYTE_SECOND;
      end else begin
        pc_next    = pc_load ? pc_load_addr : pc + 12'd1;
        state_next = BYTE_FIRST;
        fetch_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BYTE_FIRST;
      pc          <= '0;
      opr         <= '0;
      opa         <= '0;
      operand     <= '0;
      two_byte    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_valid <= fetch_done;

      if (phase == M1) begin
        if (state == BYTE_FIRST) opr <= nibble;
        else                     operand[7:4] <= nibble;
      end
      if (phase == M2) begin
        if (state == BYTE_FIRST) opa <= nibble;
        else                     operand[3:0] <= nibble;
      end

      // A one-byte instruction finishes in FIRST and must not show a stale
      // operand left over from an earlier two-byte instruction.
      if (fetch_done) begin
        two_byte <= (state == BYTE_SECOND);
        if (state == BYTE_FIRST) operand <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a behavioural ROM driving nibble by
// sub-cycle. Outputs are sampled on the falling clock edge.
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cycle;
  logic [11:0] addr;
  logic [3:0]  nibble;
  logic        hold;
  logic        pc_load;
  logic [11:0] pc_load_addr;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  operand;
  logic        two_byte;
  logic        instr_valid;

  logic [7:0]  rom [0:4095];
  int          n_vec = 0;
  int          n_err = 0;
  int          n;

  ifetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cycle        (cycle),
    .addr         (addr),
    .nibble       (nibble),
    .hold         (hold),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .opr          (opr),
    .opa          (opa),
    .operand      (operand),
    .two_byte     (two_byte),
    .instr_valid  (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outside M1/M2 the bus carries junk the fetch unit must ignore.
  assign nibble = (cycle == 3'd3) ? rom[addr][7:4] :
                  (cycle == 3'd4) ? rom[addr][3:0] : 4'hA;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // Hold reset over a falling edge, release it there; the next rising edge
  // is the first A1->A2 step.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Count rising edges until instr_valid is seen; -1 if the budget runs out.
  task automatic wait_pulse(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr_valid) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Advance on falling edges until cycle/addr match; 0 if never reached.
  task automatic wait_for(input logic [2:0] cyc, input logic [11:0] a, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cycle == cyc && addr == a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic ok;

  initial begin
    rst_n        = 1'b0;
    hold         = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = 12'h000;
    clear_rom();
    @(negedge clk);

    // Reset state
    check("rst_cycle",    cycle, 0);
    check("rst_addr",     addr, 0);
    check("rst_opr_opa",  {opr, opa}, 0);
    check("rst_operand",  operand, 0);
    check("rst_flags",    {two_byte, instr_valid}, 0);

    // Three one-byte instructions, 8 clocks apart
    rom[0] = 8'h00; rom[1] = 8'h85; rom[2] = 8'h97;
    do_reset();
    wait_pulse(n);
    check("nop_latency", n, 8);
    check("nop_fields",  {opr, opa, operand, two_byte}, {4'h0, 4'h0, 8'h00, 1'b0});
    check("nop_addr",    addr, 12'h001);
    @(posedge clk); @(negedge clk);
    check("pulse_width", instr_valid, 0);
    wait_pulse(n);
    check("i85_latency", n, 7);
    check("i85_fields",  {opr, opa, two_byte}, {4'h8, 4'h5, 1'b0});
    check("i85_addr",    addr, 12'h002);
    wait_pulse(n);
    check("i97_latency", n, 8);
    check("i97_fields",  {opr, opa}, {4'h9, 4'h7});
    check("i97_addr",    addr, 12'h003);

    // JUN: two bytes, pulse only after 16 clocks
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h10;
    do_reset();
    wait_pulse(n);
    check("jun_latency", n, 16);
    check("jun_fields",  {opr, opa, operand, two_byte}, {4'h4, 4'h0, 8'h10, 1'b1});
    check("jun_addr",    addr, 12'h002);

    // FIM is two bytes, SRC one byte with operand cleared
    clear_rom();
    rom[0] = 8'h22; rom[1] = 8'h5A; rom[2] = 8'h23;
    do_reset();
    wait_pulse(n);
    check("fim_latency", n, 16);
    check("fim_fields",  {opr, opa, operand, two_byte}, {4'h2, 4'h2, 8'h5A, 1'b1});
    wait_pulse(n);
    check("src_latency", n, 8);
    check("src_fields",  {opr, opa, operand, two_byte}, {4'h2, 4'h3, 8'h00, 1'b0});
    check("src_addr",    addr, 12'h003);

    // PC wrap, jump, and wrap between the two bytes of an instruction
    clear_rom();
    do_reset();
    pc_load = 1'b1; pc_load_addr = 12'hFFF;
    wait_pulse(n);
    check("load_fff",    addr, 12'hFFF);
    pc_load = 1'b0;
    wait_pulse(n);
    check("wrap_addr",   addr, 12'h000);
    pc_load = 1'b1; pc_load_addr = 12'h123;
    wait_pulse(n);
    check("load_123",    addr, 12'h123);
    pc_load_addr = 12'hFFF;
    wait_pulse(n);
    check("load_fff_2",  addr, 12'hFFF);
    rom[12'hFFF] = 8'h50; rom[0] = 8'h21;
    // pc_load is still high while the JMS first byte closes: must be ignored
    pc_load_addr = 12'h0F0;
    wait_for(3'd3, 12'h000, ok);
    check("jms_wrap_2nd", ok, 1);
    pc_load = 1'b0;
    wait_pulse(n);
    check("jms_fields",  {opr, opa, operand, two_byte}, {4'h5, 4'h0, 8'h21, 1'b1});
    check("jms_addr",    addr, 12'h001);

    // Hold for 5 clocks at X3
    clear_rom();
    do_reset();
    wait_for(3'd7, 12'h000, ok);
    check("reach_x3",    ok, 1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_state", {cycle, addr, instr_valid}, {3'd7, 12'h000, 1'b0});
    end
    hold = 1'b0;
    @(posedge clk); @(negedge clk);
    check("hold_resume", {cycle, addr, instr_valid}, {3'd0, 12'h001, 1'b1});

    // Reset during M1 of the JUN second byte
    rom[0] = 8'h40; rom[1] = 8'h10;
    do_reset();
    wait_for(3'd3, 12'h001, ok);
    check("reach_m1_2nd", ok, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_state", {cycle, addr, instr_valid, opr}, {3'd0, 12'h000, 1'b0, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_step", {cycle, addr, instr_valid}, {3'd1, 12'h000, 1'b0});
    wait_pulse(n);
    check("midrst_lat",  n, 15);
    check("midrst_jun",  {opr, operand, two_byte, addr}, {4'h4, 8'h10, 1'b1, 12'h002});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
